// File: rtl/load_store_unit_if.sv
// Data-memory port bundle between the load/store unit and data memory.
interface load_store_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                memReq;
   logic                memWe;
   logic [ADDR_W-1:0]   memAddr;
   logic [DATA_W-1:0]   memWdata;
   logic [DATA_W/8-1:0] memBe;
   logic                memReady;
   logic [DATA_W-1:0]   memRdata;

   modport master (
      output memReq, memWe, memAddr, memWdata, memBe,
      input  memReady, memRdata
   );

   modport slave (
      input  memReq, memWe, memAddr, memWdata, memBe,
      output memReady, memRdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with word-addressed req/ready memory port.
// MISALIGNED_SPLIT_EN: serve word-crossing accesses as two handshakes.
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] storeData,
   output logic              stall,
   output logic [DATA_W-1:0] loadData,
   output logic              loadValid,
   output logic              misaligned,
   load_store_unit_if.master mem
);
   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACCESS2,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } size_e;

   function automatic size_e size_of(input logic [2:0] f3);
      unique case (f3[1:0])
         2'b00:   size_of = SZ_B;
         2'b01:   size_of = SZ_H;
         default: size_of = SZ_W;
      endcase
   endfunction

   state_e st, nxt;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_lo;
   size_e             r_sz;
   logic              r_sgn;
   logic              r_store;
   logic              r_err;
   logic              r_split;

   logic              req;
   logic [OFF_W-1:0]  in_off;
   size_e             in_sz;
   logic              in_bad;
   logic              in_cross;
   logic              req_err;
   logic              req_split;

   assign req      = memRead | memWrite;
   assign in_off   = addr[OFF_W-1:0];
   assign in_sz    = size_of(funct3);
   assign in_bad   = (in_sz == SZ_H && in_off[0])
                   || (in_sz == SZ_W && in_off != '0);
   assign in_cross = (in_sz == SZ_W && in_off != '0)
                   || (in_sz == SZ_H && in_off == '1);
   assign req_err   = SPLIT_EN ? 1'b0 : in_bad;
   assign req_split = SPLIT_EN ? in_cross : 1'b0;

   logic [OFF_W-1:0] r_off;
   logic [OFF_W+2:0] sh;
   logic             in_acc;
   logic             hi_phase;

   assign r_off    = r_addr[OFF_W-1:0];
   assign sh       = {r_off, 3'b000};
   assign in_acc   = (st == ACCESS) || (st == ACCESS2);
   assign hi_phase = (st == ACCESS2);

   // Next-state logic
   always_comb begin
      nxt = st;
      unique case (st)
         IDLE: begin
            if (req) nxt = req_err ? DONE : ACCESS;
         end
         ACCESS: begin
            if (mem.memReady) nxt = r_split ? ACCESS2 : DONE;
         end
         ACCESS2: begin
            if (mem.memReady) nxt = DONE;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Load path: merge both words when split, align, then extend
   logic [DATA_W-1:0] lo_src;
   logic [DATA_W-1:0] hi_src;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] ext;
   logic              ld_fin;

   always_comb begin
      lo_src  = hi_phase ? r_lo : mem.memRdata;
      hi_src  = hi_phase ? mem.memRdata : '0;
      shifted = DATA_W'({hi_src, lo_src} >> sh);
      unique case (r_sz)
         SZ_B:    ext = {{(DATA_W-8){r_sgn & shifted[7]}},
                         shifted[7:0]};
         SZ_H:    ext = {{(DATA_W-16){r_sgn & shifted[15]}},
                         shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   assign ld_fin = !r_store && mem.memReady
                && ((st == ACCESS && !r_split) || hi_phase);

   // Store path: upper halves only matter for the second handshake
   logic [BE_W-1:0]     be_base;
   logic [2*BE_W-1:0]   be_wide;
   logic [2*DATA_W-1:0] wd_wide;

   always_comb begin
      unique case (r_sz)
         SZ_B:    be_base = BE_W'(1);
         SZ_H:    be_base = BE_W'(3);
         default: be_base = '1;
      endcase
      be_wide = {{BE_W{1'b0}}, be_base} << r_off;
      wd_wide = {{DATA_W{1'b0}}, r_wdata} << sh;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_lo     <= '0;
         r_sz     <= SZ_W;
         r_sgn    <= 1'b0;
         r_store  <= 1'b0;
         r_err    <= 1'b0;
         r_split  <= 1'b0;
         loadData <= '0;
      end else begin
         st <= nxt;
         if (st == IDLE && req) begin
            r_addr  <= addr;
            r_wdata <= storeData;
            r_sz    <= in_sz;
            r_sgn   <= !funct3[2];
            r_store <= memWrite;
            r_err   <= req_err;
            r_split <= req_split;
         end
         if (st == ACCESS && mem.memReady) r_lo <= mem.memRdata;
         if (ld_fin) loadData <= ext;
      end
   end

   logic [ADDR_W-1:0] base;
   assign base = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   assign mem.memReq   = in_acc;
   assign mem.memWe    = in_acc & r_store;
   assign mem.memAddr  = !in_acc ? '0
                       : hi_phase ? base + ADDR_W'(BE_W) : base;
   assign mem.memBe    = !in_acc ? '0
                       : hi_phase ? be_wide[2*BE_W-1:BE_W]
                       : be_wide[BE_W-1:0];
   assign mem.memWdata = !(in_acc && r_store) ? '0
                       : hi_phase ? wd_wide[2*DATA_W-1:DATA_W]
                       : wd_wide[DATA_W-1:0];

   assign stall      = (st == IDLE && req) || in_acc;
   assign loadValid  = (st == DONE) && !r_store && !r_err;
   assign misaligned = (st == DONE) && r_err;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic [2:0]  funct3 = 3'b010;
   logic [31:0] addr = '0;
   logic [31:0] storeData = '0;
   logic        stall;
   logic [31:0] loadData;
   logic        loadValid;
   logic        misaligned;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_ld = '0;

   load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) mif ();

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk),
      .reset(reset),
      .memRead(memRead),
      .memWrite(memWrite),
      .funct3(funct3),
      .addr(addr),
      .storeData(storeData),
      .stall(stall),
      .loadData(loadData),
      .loadValid(loadValid),
      .misaligned(misaligned),
      .mem(mif)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mif.memReady = 1'b0;
      mif.memRdata = '0;
      step(); step();
      mid();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
      checks++; if (mif.memReq !== 1'b0) begin errors++; $display("FAIL rst_memReq: got %b expected 0", mif.memReq); end
      checks++; if (loadValid !== 1'b0) begin errors++; $display("FAIL rst_loadValid: got %b expected 0", loadValid); end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rst_misaligned: got %b expected 0", misaligned); end
      checks++; if (loadData !== 32'h0) begin errors++; $display("FAIL rst_loadData: got %h expected 0", loadData); end
      step();
      reset = 1'b0;
      mid();
   endtask

   task automatic test_lw();
      step();
      memRead = 1'b1; funct3 = 3'b010; addr = 32'h10;
      mid();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_c0_stall: got %b expected 1", stall); end
      checks++; if (mif.memReq !== 1'b0) begin errors++; $display("FAIL lw_c0_memReq: got %b expected 0", mif.memReq); end
      step();
      memRead = 1'b0; mif.memReady = 1'b1; mif.memRdata = 32'hDEADBEEF;
      mid();
      checks++; if (mif.memReq !== 1'b1) begin errors++; $display("FAIL lw_c1_memReq: got %b expected 1", mif.memReq); end
      checks++; if (mif.memAddr !== 32'h10) begin errors++; $display("FAIL lw_c1_memAddr: got %h expected 00000010", mif.memAddr); end
      checks++; if (mif.memWe !== 1'b0) begin errors++; $display("FAIL lw_c1_memWe: got %b expected 0", mif.memWe); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_c1_stall: got %b expected 1", stall); end
      step();
      mif.memReady = 1'b0; mif.memRdata = 32'h0;
      mid();
      checks++; if (loadValid !== 1'b1) begin errors++; $display("FAIL lw_c2_loadValid: got %b expected 1", loadValid); end
      checks++; if (loadData !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_c2_loadData: got %h expected deadbeef", loadData); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_c2_stall: got %b expected 0", stall); end
      step();
      mid();
      checks++; if (loadValid !== 1'b0) begin errors++; $display("FAIL lw_c3_loadValid: got %b expected 0", loadValid); end
      checks++; if (loadData !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_c3_hold: got %h expected deadbeef", loadData); end
      last_ld = 32'hDEADBEEF;
   endtask

   task automatic test_sub_word_loads();
      logic [2:0]  f3_t [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] ad_t [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
      logic [31:0] ex_t [4] = '{32'hFFFFFF80, 32'h00000080,
                                32'hFFFF80FF, 32'h000080FF};
      for (int i = 0; i < 4; i++) begin
         step();
         memRead = 1'b1; funct3 = f3_t[i]; addr = ad_t[i];
         step();
         memRead = 1'b0; mif.memReady = 1'b1; mif.memRdata = 32'h80FF0000;
         mid();
         checks++; if (mif.memAddr !== 32'h10) begin errors++; $display("FAIL sub_memAddr[%0d]: got %h expected 00000010", i, mif.memAddr); end
         step();
         mif.memReady = 1'b0;
         mid();
         checks++; if (loadValid !== 1'b1) begin errors++; $display("FAIL sub_loadValid[%0d]: got %b expected 1", i, loadValid); end
         checks++; if (loadData !== ex_t[i]) begin errors++; $display("FAIL sub_loadData[%0d]: got %h expected %h", i, loadData, ex_t[i]); end
         last_ld = ex_t[i];
      end
   endtask

   task automatic test_stores();
      logic [2:0]  f3_t [3] = '{3'b001, 3'b000, 3'b010};
      logic [31:0] ad_t [3] = '{32'h22, 32'h21, 32'h30};
      logic [31:0] sd_t [3] = '{32'h1234ABCD, 32'h1234ABEF, 32'hCAFEF00D};
      logic [31:0] ma_t [3] = '{32'h20, 32'h20, 32'h30};
      logic [3:0]  be_t [3] = '{4'b1100, 4'b0010, 4'b1111};
      logic [31:0] wd_t [3] = '{32'hABCD0000, 32'h34ABEF00, 32'hCAFEF00D};
      for (int i = 0; i < 3; i++) begin
         step();
         memWrite = 1'b1; funct3 = f3_t[i]; addr = ad_t[i];
         storeData = sd_t[i];
         step();
         memWrite = 1'b0; mif.memReady = 1'b1;
         mid();
         checks++; if (mif.memWe !== 1'b1) begin errors++; $display("FAIL st_memWe[%0d]: got %b expected 1", i, mif.memWe); end
         checks++; if (mif.memAddr !== ma_t[i]) begin errors++; $display("FAIL st_memAddr[%0d]: got %h expected %h", i, mif.memAddr, ma_t[i]); end
         checks++; if (mif.memBe !== be_t[i]) begin errors++; $display("FAIL st_memBe[%0d]: got %b expected %b", i, mif.memBe, be_t[i]); end
         checks++; if (mif.memWdata !== wd_t[i]) begin errors++; $display("FAIL st_memWdata[%0d]: got %h expected %h", i, mif.memWdata, wd_t[i]); end
         step();
         mif.memReady = 1'b0;
         mid();
         checks++; if (loadValid !== 1'b0) begin errors++; $display("FAIL st_loadValid[%0d]: got %b expected 0", i, loadValid); end
         checks++; if (stall !== 1'b0) begin errors++; $display("FAIL st_stall[%0d]: got %b expected 0", i, stall); end
         checks++; if (loadData !== last_ld) begin errors++; $display("FAIL st_loadData_hold[%0d]: got %h expected %h", i, loadData, last_ld); end
      end
   endtask

   task automatic test_wait_states();
      step();
      memRead = 1'b1; funct3 = 3'b010; addr = 32'h10;
      mid();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ws_c0_stall: got %b expected 1", stall); end
      for (int c = 1; c <= 4; c++) begin
         step();
         memRead = 1'b0;
         mif.memReady = (c == 4);
         mif.memRdata = (c == 4) ? 32'h12345678 : 32'h0BAD0BAD;
         mid();
         checks++; if (mif.memReq !== 1'b1 || mif.memAddr !== 32'h10) begin errors++; $display("FAIL ws_req_c%0d: got req %b addr %h expected 1 00000010", c, mif.memReq, mif.memAddr); end
         checks++; if (stall !== 1'b1 || loadValid !== 1'b0) begin errors++; $display("FAIL ws_stall_c%0d: got stall %b lv %b expected 1 0", c, stall, loadValid); end
      end
      step();
      mif.memReady = 1'b0;
      mid();
      checks++; if (loadValid !== 1'b1) begin errors++; $display("FAIL ws_c5_loadValid: got %b expected 1", loadValid); end
      checks++; if (loadData !== 32'h12345678) begin errors++; $display("FAIL ws_c5_loadData: got %h expected 12345678", loadData); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ws_c5_stall: got %b expected 0", stall); end
      last_ld = 32'h12345678;
   endtask

`ifdef MISALIGNED_SPLIT_EN
   task automatic test_misaligned();
      step();
      memRead = 1'b1; funct3 = 3'b010; addr = 32'h12;
      step();
      memRead = 1'b0; mif.memReady = 1'b1; mif.memRdata = 32'h11223344;
      mid();
      checks++; if (mif.memAddr !== 32'h10 || mif.memReq !== 1'b1) begin errors++; $display("FAIL sp_addr0: got req %b addr %h expected 1 00000010", mif.memReq, mif.memAddr); end
      step();
      mif.memRdata = 32'h55667788;
      mid();
      checks++; if (mif.memAddr !== 32'h14 || mif.memReq !== 1'b1) begin errors++; $display("FAIL sp_addr1: got req %b addr %h expected 1 00000014", mif.memReq, mif.memAddr); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sp_stall: got %b expected 1", stall); end
      step();
      mif.memReady = 1'b0;
      mid();
      checks++; if (loadValid !== 1'b1 || misaligned !== 1'b0) begin errors++; $display("FAIL sp_done: got lv %b mis %b expected 1 0", loadValid, misaligned); end
      checks++; if (loadData !== 32'h77881122) begin errors++; $display("FAIL sp_loadData: got %h expected 77881122", loadData); end
      last_ld = 32'h77881122;
   endtask
`else
   task automatic test_misaligned();
      logic [2:0]  f3_t [2] = '{3'b010, 3'b001};
      logic [31:0] ad_t [2] = '{32'h12, 32'h23};
      for (int i = 0; i < 2; i++) begin
         step();
         memRead = (i == 0); memWrite = (i == 1);
         funct3 = f3_t[i]; addr = ad_t[i];
         mid();
         checks++; if (stall !== 1'b1 || mif.memReq !== 1'b0) begin errors++; $display("FAIL mis_c0[%0d]: got stall %b req %b expected 1 0", i, stall, mif.memReq); end
         step();
         memRead = 1'b0; memWrite = 1'b0; mif.memReady = 1'b1;
         mid();
         checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse[%0d]: got %b expected 1", i, misaligned); end
         checks++; if (stall !== 1'b0 || mif.memReq !== 1'b0 || loadValid !== 1'b0) begin errors++; $display("FAIL mis_c1[%0d]: got stall %b req %b lv %b expected 0 0 0", i, stall, mif.memReq, loadValid); end
         step();
         mif.memReady = 1'b0;
         mid();
         checks++; if (misaligned !== 1'b0 || mif.memReq !== 1'b0) begin errors++; $display("FAIL mis_c2[%0d]: got mis %b req %b expected 0 0", i, misaligned, mif.memReq); end
         checks++; if (loadData !== last_ld) begin errors++; $display("FAIL mis_hold[%0d]: got %h expected %h", i, loadData, last_ld); end
      end
   endtask
`endif

   task automatic test_back_to_back();
      step();
      memRead = 1'b1; funct3 = 3'b010; addr = 32'h10;
      step();
      mif.memReady = 1'b1; mif.memRdata = 32'hAAAA5555;
      step();
      mif.memReady = 1'b0;
      mid();
      checks++; if (loadValid !== 1'b1 || stall !== 1'b0 || mif.memReq !== 1'b0) begin errors++; $display("FAIL b2b_done: got lv %b stall %b req %b expected 1 0 0", loadValid, stall, mif.memReq); end
      step();
      addr = 32'h14;
      mid();
      checks++; if (stall !== 1'b1 || mif.memReq !== 1'b0) begin errors++; $display("FAIL b2b_idle: got stall %b req %b expected 1 0", stall, mif.memReq); end
      step();
      memRead = 1'b0; mif.memReady = 1'b1; mif.memRdata = 32'h5555AAAA;
      mid();
      checks++; if (mif.memAddr !== 32'h14) begin errors++; $display("FAIL b2b_addr: got %h expected 00000014", mif.memAddr); end
      step();
      mif.memReady = 1'b0;
      mid();
      checks++; if (loadData !== 32'h5555AAAA || loadValid !== 1'b1) begin errors++; $display("FAIL b2b_data: got %h lv %b expected 5555aaaa 1", loadData, loadValid); end
      last_ld = 32'h5555AAAA;
      step();
      memRead = 1'b1; memWrite = 1'b1; funct3 = 3'b010; addr = 32'h50;
      storeData = 32'hA5A5A5A5;
      step();
      memRead = 1'b0; memWrite = 1'b0; mif.memReady = 1'b1;
      mid();
      checks++; if (mif.memWe !== 1'b1 || mif.memWdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL both_we: got we %b wd %h expected 1 a5a5a5a5", mif.memWe, mif.memWdata); end
      step();
      mif.memReady = 1'b0;
      mid();
      checks++; if (loadValid !== 1'b0) begin errors++; $display("FAIL both_lv: got %b expected 0", loadValid); end
   endtask

   task automatic test_reset_mid_access();
      step();
      memRead = 1'b1; funct3 = 3'b010; addr = 32'h40;
      step();
      memRead = 1'b0; mif.memReady = 1'b0;
      mid();
      checks++; if (mif.memReq !== 1'b1) begin errors++; $display("FAIL rm_req: got %b expected 1", mif.memReq); end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      mid();
      checks++; if (mif.memReq !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rm_after: got req %b stall %b expected 0 0", mif.memReq, stall); end
      checks++; if (loadValid !== 1'b0 || loadData !== 32'h0) begin errors++; $display("FAIL rm_lv: got lv %b data %h expected 0 0", loadValid, loadData); end
      step();
      mif.memReady = 1'b1;
      mid();
      checks++; if (loadValid !== 1'b0 || mif.memReq !== 1'b0) begin errors++; $display("FAIL rm_idle: got lv %b req %b expected 0 0", loadValid, mif.memReq); end
      step();
      mif.memReady = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_lw();
      test_sub_word_loads();
      test_stores();
      test_wait_states();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
